// File: rtl/demux12_4_pkg.sv
// Shared constants and helpers for the 1-to-2 nibble demultiplexer.
// Channel encoding doubles as the round-robin pointer value.
package demux12_4_pkg;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Channel that the current input would be routed to.
    function automatic logic pick_target(input logic rr_mode, input logic rr_ptr, input logic sel);
        return rr_mode ? rr_ptr : sel;
    endfunction

endpackage

// File: rtl/demux12_4_out_slot.sv
// One output channel: single-entry holding register, valid flag and a
// wrapping count of nibbles loaded into it.
module demux_out_slot #(
    parameter int DATA_W = demux12_4_pkg::DATA_W,
    parameter int CNT_W  = demux12_4_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              drain_ready,
    input  logic              clr,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              empty_or_draining,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              drain;

    assign drain = valid_q & drain_ready;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;

        // A load in the same cycle as a drain keeps the slot occupied.
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (drain) begin
            valid_d = 1'b0;
        end

        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign data              = data_q;
    assign valid             = valid_q;
    assign empty_or_draining = ~valid_q | drain_ready;
    assign count             = count_q;

endmodule

// File: rtl/demux12_4.sv
// Registered 1-to-2 nibble demultiplexer / deinterleaver with per-channel
// valid/ready outputs, selectable or round-robin routing.
module demux12_4
    import demux12_4_pkg::*;
#(
    parameter int DATA_W = demux12_4_pkg::DATA_W,
    parameter int CNT_W  = demux12_4_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] demux_In,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sel,
    input  logic              rr_mode,
    input  logic              clr_cnt,
    output logic [DATA_W-1:0] demux_Out0,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] demux_Out1,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    logic rr_ptr_q, rr_ptr_d;
    logic tgt;
    logic accept;
    logic load0, load1;
    logic room0, room1;

    assign tgt = pick_target(rr_mode, rr_ptr_q, sel);

    // Readiness looks only at the target slot, so a blocked target stalls
    // the input rather than spilling to the other channel.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            in_ready = (tgt == CH1) ? room1 : room0;
        end
    end

    assign accept = in_valid & in_ready;
    assign load0  = accept & (tgt == CH0);
    assign load1  = accept & (tgt == CH1);

    always_comb begin
        rr_ptr_d = CH0;
        if (rr_mode) begin
            rr_ptr_d = accept ? ~rr_ptr_q : rr_ptr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= CH0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    demux_out_slot #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_slot0 (
        .clk               (clk),
        .rst               (rst),
        .load              (load0),
        .load_data         (demux_In),
        .drain_ready       (out0_ready),
        .clr               (clr_cnt),
        .data              (demux_Out0),
        .valid             (out0_valid),
        .empty_or_draining (room0),
        .count             (cnt0)
    );

    demux_out_slot #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_slot1 (
        .clk               (clk),
        .rst               (rst),
        .load              (load1),
        .load_data         (demux_In),
        .drain_ready       (out1_ready),
        .clr               (clr_cnt),
        .data              (demux_Out1),
        .valid             (out1_valid),
        .empty_or_draining (room1),
        .count             (cnt1)
    );

endmodule

// File: doc/demux12_4.md
Name: demux12_4

Overview:
- Registered 1-to-2 demultiplexer and deinterleaver for 4-bit data. It is the receive-side counterpart of the 2:1 nibble multiplexer.
- Accepts one nibble per cycle on a valid/ready input and routes it to one of two output channels. The channel is chosen by `sel`, or by round-robin alternation when `rr_mode` is high.
- Each output channel has a one-entry holding register and its own valid/ready handshake.
- Sits between a time-multiplexed nibble link and two independent consumers.

Parameters:
- DATA_W, 4, width of data nibble on input and both outputs
- CNT_W, 8, width of per-channel transfer counters

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- demux_In  in  DATA_W  input data
- in_valid  in  1  input data valid
- in_ready  out  1  block can accept `demux_In` this cycle
- sel  in  1  target channel when `rr_mode`=0 (0 → ch0, 1 → ch1)
- rr_mode  in  1  1 = ignore `sel`, alternate ch0,ch1,ch0,...
- clr_cnt  in  1  synchronous clear of both transfer counters
- demux_Out0  out  DATA_W  channel 0 data (registered)
- out0_valid  out  1  channel 0 holds data
- out0_ready  in  1  channel 0 consumer accepts
- demux_Out1  out  DATA_W  channel 1 data (registered)
- out1_valid  out  1  channel 1 holds data
- out1_ready  in  1  channel 1 consumer accepts
- cnt0  out  CNT_W  transfers accepted into channel 0
- cnt1  out  CNT_W  transfers accepted into channel 1

Behaviour:
- Reset (async, rst=1): `out0_valid` = `out1_valid` = 0; `demux_Out0` = `demux_Out1` = 0; `cnt0` = `cnt1` = 0; `rr_ptr` = 0. `in_ready` is 0 while rst=1.
- Reset mid-operation: held data is discarded, no partial transfer completes, counters clear. The first accept after release goes to ch0 when `rr_mode`=1.
- Target channel: `tgt = rr_mode ? rr_ptr : sel`. This is combinational on the current-cycle inputs.
- Drain: channel k drains when `outk_valid`=1 and `outk_ready`=1.
- Ready rule: `in_ready` = 1 when the target channel slot is empty, or the slot drains this cycle (full-throughput pass-through). `in_ready` must not depend on `in_valid`.
- Accept: `in_valid`=1 and `in_ready`=1.
  - On the next edge, the target slot loads `demux_In` and sets its valid.
  - The target counter increments.
  - In rr mode, `rr_ptr` toggles.
- Non-target slot: unaffected by an accept.
- Latency: data accepted in cycle N appears on `demux_Outk` with `outk_valid`=1 in cycle N+1.
- Drain without reload: the slot's valid clears on the next edge. Its data register holds its last value.
- Simultaneous drain and accept into the same slot: valid stays 1 and data updates to the new nibble.
- Simultaneous drain on the other channel: independent, no interaction.
- Full slot, not draining: `in_ready`=0 for that target. Input data must be held by the upstream; no data is dropped or overwritten.
- Blocked target: a blocked target does not let data pass to the other channel. In rr mode, `rr_ptr` does not advance until the accept occurs.
- `rr_ptr` while `rr_mode`=0: forced to 0 each cycle, so entering rr mode always starts at ch0.
- Mode changes: `rr_mode` or `sel` may change any cycle. Routing uses only the value present in the cycle of the accept.
- Counters: CNT_W bits, wrap from 2^CNT_W-1 to 0 with no flag.
  - `clr_cnt`=1 zeroes both counters on the next edge.
  - If `clr_cnt` and an accept coincide, the clear wins and the count ends at 0.
- Output data is stable while `outk_valid`=1 and `outk_ready`=0.

Decomposition:
- Shared package `demux12_4_pkg`:
  - constants DATA_W=4, CNT_W=8
  - channel encoding constants CH0=1'b0, CH1=1'b1
- One natural sub-module, `demux_out_slot`, instantiated twice:
  - holding register, valid flag and transfer counter
  - inputs: load, load_data, drain_ready, clr
  - outputs: data, valid, empty_or_draining, count
- Top level holds the target select, `rr_ptr` and `in_ready` logic.

Test Plan:
- Reset then `sel`=0, `demux_In`=4'hA, `in_valid`=1 for one cycle, `out0_ready`=1 → next cycle `demux_Out0`=A, `out0_valid`=1, `out1_valid`=0, `cnt0`=1, `cnt1`=0.
- `rr_mode`=1, stream 1,2,3,4 back-to-back, both ready=1 → ch0 receives 1,3 and ch1 receives 2,4, each one cycle after accept; `cnt0`=`cnt1`=2, `in_ready` held at 1 throughout.
- `out1_ready`=0, `sel`=1, send 5 then 6 → 5 held on `demux_Out1`, `in_ready`=0 while 6 is presented. Raise `out1_ready` → same-cycle drain and accept; next cycle `demux_Out1`=6, valid stays 1.
- `rr_mode`=1, ch0 blocked with `rr_ptr`=0 → `in_ready`=0, `rr_ptr` stays 0, ch1 receives nothing. On unblock, accept goes to ch0, then `rr_ptr`=1.
- 256 accepts into ch0 → `cnt0` wraps to 0. Then `clr_cnt`=1 with a simultaneous accept to ch1 → `cnt1`=0 after the edge.
- Assert rst asynchronously mid-stream with both slots full → outputs and counters go to 0 immediately. After release with `rr_mode`=1, the first nibble lands on ch0.
